uart_tx_9bit: RTL and testbench
===============================

Name: uart_tx_9bit

Overview:
- Serial transmitter for the 8-data/1-stop framing that the team's UART receiver path consumes.
- Accepts a parallel byte with a single-cycle start strobe.
- Emits start bit, 8 data bits MSB-first, then stop bit, each held for CLKS_PER_BIT clocks.
- Sits between the packet/response logic and the off-chip serial line; provides busy/done status for upstream sequencing.

Parameters:
- CLKS_PER_BIT, 10, clock cycles per serial bit period; legal range 2..1023.

Ports:
- clk  input  1  system clock, rising-edge.
- n_rst  input  1  asynchronous active-low reset.
- tx_start  input  1  request to send tx_data; sampled only when tx_busy=0.
- tx_data  input  8  byte to transmit; captured on the accepting edge.
- serial_out  output  1  serial line; idle/stop level 1, start level 0.
- tx_busy  output  1  high from the accepting edge until the frame completes.
- tx_done  output  1  one-cycle pulse after the stop bit completes.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low on n_rst.
- All outputs are registered.
- Reset values (asynchronous, immediate): state IDLE, serial_out=1, tx_busy=0, tx_done=0, bit counter=0, baud counter=0, data register=0.
- Reset mid-frame aborts the frame: line returns to 1 at once; no tx_done is produced.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - serial_out=1.
  - tx_start=1 at an edge: capture tx_data into the shift register, clear the counters, go to START.
  - That same edge sets serial_out=0 and tx_busy=1 (latency: 1 clock from strobe to line).
- START: serial_out=0 for CLKS_PER_BIT cycles, then go to DATA with serial_out=data[7].
- DATA:
  - Each bit is held CLKS_PER_BIT cycles; bits are sent in order data[7] down to data[0].
  - Bit counter counts 0..7; the shift register shifts toward MSB at each bit boundary.
  - After bit index 7 completes, go to STOP with serial_out=1.
- STOP: serial_out=1 for CLKS_PER_BIT cycles, then go to IDLE.
  - The transition edge sets tx_busy=0 and tx_done=1 for exactly one cycle.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
  - Width is clog2(CLKS_PER_BIT); no drift across a frame.
- Frame length: exactly 10*CLKS_PER_BIT cycles with serial_out driven by the frame; tx_busy is high for the same 10*CLKS_PER_BIT cycles.
- tx_start while tx_busy=1 is ignored; it is neither queued nor allowed to corrupt the frame in flight.
- tx_data changes during a frame have no effect.
- Back-to-back operation:
  - tx_start may be asserted in the tx_done cycle, since tx_busy=0 there.
  - It is accepted, giving exactly one idle-high cycle between the stop bit and the next start bit.
- tx_start held high continuously sends frames repeatedly, each separated by one idle cycle.
- tx_done and tx_start acceptance can coincide; tx_done still pulses for one cycle.

Test Plan:
- Reset with CLKS_PER_BIT=10, no start -> serial_out=1, tx_busy=0, tx_done=0 for 50 cycles.
- Single frame: pulse tx_start for 1 cycle with tx_data=8'hA5 -> expected response:
  - serial_out low for 10 cycles starting the edge after the strobe.
  - Then data bits 1,0,1,0,0,1,0,1 at 10 cycles each, then high for 10 cycles.
  - tx_busy high for 100 cycles, then tx_done pulses 1 cycle.
  - Loopback into the team receiver yields packet_data=8'hA5, stop_bit=1.
- Busy lockout: start 8'h3C, then at cycle 40 pulse tx_start with tx_data=8'hFF -> line carries 8'h3C only; exactly one tx_done; no second frame follows.
- Back-to-back: send 8'h00; assert tx_start with 8'hFF in the tx_done cycle -> one idle-high cycle, then a second frame with start 0, eight 1 bits, stop 1; second tx_done 101 cycles after the first.
- Reset mid-frame: assert n_rst=0 asynchronously at cycle 35 of a 8'h81 frame -> serial_out=1 and tx_busy=0 immediately, with no tx_done. After release, a new tx_start with 8'h81 sends a clean full frame.
- Parameter sweep at CLKS_PER_BIT=2 with tx_data=8'h5A -> each bit lasts 2 cycles, frame is 20 cycles, and the receiver recovers 8'h5A.

Source files
------------

// File: rtl/uart_tx_9bit.sv
// uart_tx_9bit: 8N1 MSB-first serial transmitter with busy/done status for upstream sequencing.
module uart_tx_9bit #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       serial_out,
    output logic       tx_busy,
    output logic       tx_done
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          bit_end;

    assign bit_end = baud_cnt == LAST;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            serial_out <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
            bit_cnt    <= '0;
            baud_cnt   <= '0;
            shreg      <= '0;
        end else begin
            tx_done  <= 1'b0;
            baud_cnt <= (state == IDLE || bit_end) ? '0 : baud_cnt + 1'b1;
            case (state)
                IDLE: begin
                    serial_out <= 1'b1;
                    if (tx_start) begin
                        shreg      <= tx_data;
                        bit_cnt    <= '0;
                        serial_out <= 1'b0;
                        tx_busy    <= 1'b1;
                        state      <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        serial_out <= shreg[7];
                        state      <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_cnt == 3'd7) begin
                            serial_out <= 1'b1;
                            state      <= STOP;
                        end else begin
                            // next bit is already sitting one place below the MSB
                            serial_out <= shreg[6];
                            shreg      <= {shreg[6:0], 1'b0};
                            bit_cnt    <= bit_cnt + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        tx_busy <= 1'b0;
                        tx_done <= 1'b1;
                        state   <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_9bit.sv
// tb_uart_tx_9bit: two instances (10 and 2 clocks per bit) checked every cycle against a frame-timeline model.
module tb_uart_tx_9bit;
    localparam int CPB[2] = '{10, 2};

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       so[2];
    logic       bz[2];
    logic       dn[2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : gi
        uart_tx_9bit #(.CLKS_PER_BIT(CPB[g])) dut (
            .clk(clk),
            .n_rst(n_rst),
            .tx_start(tx_start),
            .tx_data(tx_data),
            .serial_out(so[g]),
            .tx_busy(bz[g]),
            .tx_done(dn[g])
        );
    end

    // model: a frame is a timeline of 10*CPB cycles indexed from the accepting edge
    logic       m_busy[2] = '{1'b0, 1'b0};
    logic       m_done[2] = '{1'b0, 1'b0};
    int         m_t[2] = '{0, 0};
    logic [7:0] m_byte[2] = '{8'h00, 8'h00};

    always @(posedge clk or negedge n_rst) begin
        for (int g = 0; g < 2; g++) begin
            if (!n_rst) begin
                m_busy[g] = 1'b0;
                m_done[g] = 1'b0;
                m_t[g] = 0;
            end else begin
                m_done[g] = 1'b0;
                if (m_busy[g]) begin
                    m_t[g]++;
                    if (m_t[g] == 10 * CPB[g]) begin
                        m_busy[g] = 1'b0;
                        m_done[g] = 1'b1;
                    end
                end else if (tx_start) begin
                    m_busy[g] = 1'b1;
                    m_t[g] = 0;
                    m_byte[g] = tx_data;
                end
            end
        end
    end

    function automatic logic exp_line(input int g);
        int k;
        if (!m_busy[g]) return 1'b1;
        k = m_t[g] / CPB[g];
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return m_byte[g][8-k];
    endfunction

    int done_cnt[2] = '{0, 0};
    int busy_cnt[2] = '{0, 0};

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pulse(input logic [7:0] d);
        tx_data = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    // bench-side receiver: called at the first negedge showing the start bit, samples mid-bit
    task automatic rx_frame(input int g, output logic [7:0] b, output logic stp);
        int n = 0;
        b = 8'h00;
        stp = 1'b0;
        while (so[g] !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            chk("rx_start_timeout", n, 0);
            return;
        end
        repeat (CPB[g] / 2) @(negedge clk);
        for (int k = 7; k >= 0; k--) begin
            repeat (CPB[g]) @(negedge clk);
            b[k] = so[g];
        end
        repeat (CPB[g]) @(negedge clk);
        stp = so[g];
    endtask

    task automatic wait_done(input int g, output time t);
        int n = 0;
        t = 0;
        do begin
            @(negedge clk);
            n++;
        end while (dn[g] !== 1'b1 && n < 3000);
        if (n >= 3000) chk("done_timeout", n, 0);
        t = $time;
    endtask

    initial begin
        logic [7:0] b;
        logic       stp;
        time        t0, t1, t2;
        int         d0, b0;
        fork
            forever begin
                @(negedge clk);
                for (int g = 0; g < 2; g++) begin
                    checks++;
                    if (so[g] !== exp_line(g) || bz[g] !== m_busy[g] || dn[g] !== m_done[g]) begin
                        errors++;
                        $display("FAIL cycle_cmp inst%0d got so=%b busy=%b done=%b want so=%b busy=%b done=%b at %0t",
                                 g, so[g], bz[g], dn[g], exp_line(g), m_busy[g], m_done[g], $time);
                    end
                    if (dn[g] === 1'b1) done_cnt[g]++;
                    if (bz[g] === 1'b1) busy_cnt[g]++;
                end
            end
        join_none

        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        repeat (50) @(negedge clk);
        chk("idle_line", so[0], 1);
        chk("idle_busy", bz[0], 0);
        chk("idle_done", dn[0], 0);
        chk("idle_done_cnt", done_cnt[0], 0);

        b0 = busy_cnt[0];
        t0 = $time;
        pulse(8'hA5);
        rx_frame(0, b, stp);
        chk("a5_data", b, 8'hA5);
        chk("a5_stop", stp, 1);
        wait_done(0, t1);
        chk("a5_busy_cycles", busy_cnt[0] - b0, 100);
        chk("a5_done_delay", int'((t1 - t0) / 10), 101);
        repeat (30) @(negedge clk);

        d0 = done_cnt[0];
        pulse(8'h3C);
        fork
            rx_frame(0, b, stp);
            begin
                repeat (40) @(negedge clk);
                pulse(8'hFF);
            end
        join
        chk("lock_data", b, 8'h3C);
        wait_done(0, t1);
        repeat (150) @(negedge clk);
        chk("lock_one_done", done_cnt[0] - d0, 1);
        chk("lock_idle_busy", bz[0], 0);

        pulse(8'h00);
        rx_frame(0, b, stp);
        chk("b2b_first", b, 8'h00);
        wait_done(0, t1);
        pulse(8'hFF);
        rx_frame(0, b, stp);
        chk("b2b_second", b, 8'hFF);
        chk("b2b_stop", stp, 1);
        wait_done(0, t2);
        chk("b2b_gap", int'((t2 - t1) / 10), 101);
        repeat (30) @(negedge clk);

        d0 = done_cnt[0];
        pulse(8'h81);
        repeat (35) @(posedge clk);
        #3 n_rst = 1'b0;
        #1;
        chk("rst_line", so[0], 1);
        chk("rst_busy", bz[0], 0);
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        repeat (120) @(negedge clk);
        chk("rst_no_done", done_cnt[0] - d0, 0);
        pulse(8'h81);
        rx_frame(0, b, stp);
        chk("rst_refill", b, 8'h81);
        chk("rst_refill_stop", stp, 1);
        wait_done(0, t1);
        repeat (30) @(negedge clk);

        b0 = busy_cnt[1];
        t0 = $time;
        pulse(8'h5A);
        rx_frame(1, b, stp);
        chk("c2_data", b, 8'h5A);
        chk("c2_stop", stp, 1);
        wait_done(1, t1);
        chk("c2_len", int'((t1 - t0) / 10), 21);
        chk("c2_busy_cycles", busy_cnt[1] - b0, 20);
        wait_done(0, t1);
        repeat (30) @(negedge clk);

        d0 = done_cnt[0];
        tx_data = 8'hC3;
        tx_start = 1'b1;
        wait_done(0, t1);
        wait_done(0, t2);
        tx_start = 1'b0;
        chk("hold_gap", int'((t2 - t1) / 10), 101);
        repeat (150) @(negedge clk);
        chk("hold_two_done", done_cnt[0] - d0, 2);
        chk("hold_idle", so[0], 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
